// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes (also used by the transmitter) and
// the receiver FSM state encoding.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // ones_xor is the XOR of all data bits and the received parity bit.
  function automatic logic parity_bad(input int mode, input logic ones_xor);
    case (mode)
      PAR_EVEN: return ones_xor;
      PAR_ODD:  return ~ones_xor;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter: start loads a half period, every tick
// reloads a full period so ticks land on bit centres.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = run && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= HALF_LOAD;
    end else if (tick) begin
      cnt_q <= FULL_LOAD;
    end else if (run) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchroniser, frame FSM, shift register and a
// valid/ready output register with parity, framing and overrun reporting.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_d;

  rx_state_t              state_q;
  rx_state_t              state_n;

  logic [3:0]             bit_q;
  logic [DATA_W-1:0]      shift_q;
  logic                   par_err_q;
  logic                   frame_err_q;

  logic                   timer_start;
  logic                   timer_run;
  logic                   tick;
  logic                   deliver;

  // Synchroniser and previous-value flop reset to the idle (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxs_d  <= rxs;
    end
  end

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign timer_run = (state_q != RX_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(timer_start),
    .run  (timer_run),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    timer_start = 1'b0;
    deliver     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rxs_d && !rxs) begin
          state_n     = RX_START;
          timer_start = 1'b1;
        end
      end
      RX_START: begin
        if (tick) begin
          state_n = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick && (bit_q == LAST_DATA)) begin
          state_n = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (tick) begin
          state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        // Deliver at the last stop sample without waiting out the bit.
        if (tick && (bit_q == LAST_STOP)) begin
          state_n = RX_IDLE;
          deliver = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q       <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (timer_start) begin
      bit_q       <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (tick) begin
      case (state_q)
        RX_DATA: begin
          shift_q <= {rxs, shift_q[DATA_W-1:1]};
          bit_q   <= (bit_q == LAST_DATA) ? 4'd0 : bit_q + 4'd1;
        end
        RX_PARITY: begin
          par_err_q <= parity_bad(PARITY, (^shift_q) ^ rxs);
        end
        RX_STOP: begin
          if (!rxs) begin
            frame_err_q <= 1'b1;
          end
          bit_q <= (bit_q == LAST_STOP) ? 4'd0 : bit_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // A held, unaccepted character wins; the newcomer is dropped as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (deliver) begin
        if (!valid_o || ready_i) begin
          data_o       <= shift_q;
          parity_err_o <= par_err_q;
          frame_err_o  <= frame_err_q | ~rxs;
          valid_o      <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frame-level model with a per-cycle compare on the
// default instance, plus directed checks on odd-parity and 9-bit instances.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int C    = 16;
  localparam int H    = C / 2;
  localparam int SYNC = 2;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_c = 1'b1;
  logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b0;

  logic [7:0] data_a, data_b;
  logic [8:0] data_c;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic ovr_a_o, ovr_b_o, ovr_c_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t exp_q[$];
  logic       exp_valid = 1'b0, exp_pe = 1'b0, exp_fe = 1'b0, exp_ovr = 1'b0;
  logic [7:0] exp_data  = 8'h00;

  int rise_a = 0, rise_cyc_a = 0, ovr_a = 0;
  int rise_b = 0, ovr_b = 0;
  int rise_c = 0, rise_cyc_c = 0, ovr_c = 0;
  logic [8:0] cap_data_a = '0, cap_data_b = '0, cap_data_c = '0;
  logic cap_pe_a = 0, cap_fe_a = 0, cap_pe_b = 0, cap_fe_b = 0, cap_pe_c = 0, cap_fe_c = 0;
  logic prev_a = 0, prev_b = 0, prev_c = 0;

  uart_rx_os dut_a (
    .clk(clk), .rst(rst_a), .rxd(rxd_a), .data_o(data_a), .valid_o(valid_a),
    .ready_i(ready_a), .parity_err_o(perr_a), .frame_err_o(ferr_a), .overrun_o(ovr_a_o)
  );

  uart_rx_os #(.PARITY(PAR_ODD)) dut_b (
    .clk(clk), .rst(rst_a), .rxd(rxd_b), .data_o(data_b), .valid_o(valid_b),
    .ready_i(ready_b), .parity_err_o(perr_b), .frame_err_o(ferr_b), .overrun_o(ovr_b_o)
  );

  uart_rx_os #(.DATA_W(9), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst_c), .rxd(rxd_c), .data_o(data_c), .valid_o(valid_c),
    .ready_i(ready_c), .parity_err_o(perr_c), .frame_err_o(ferr_c), .overrun_o(ovr_c_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic setLine(input int which, input logic v);
    case (which)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  // Drives one frame; for instance A the expected character and its delivery
  // cycle are derived from the frame timing rules and queued for the model.
  task automatic applyStimulus(input int which, input logic [8:0] data, input int nbits,
                               input int npar, input logic pbit, input int nstop,
                               input logic stopv, output int drive_cyc);
    exp_t e;
    @(negedge clk);
    setLine(which, 1'b0);
    drive_cyc = cyc;
    if (which == 0) begin
      e.due  = drive_cyc + SYNC + H + (nbits + npar + nstop) * C;
      e.data = data[7:0];
      e.pe   = (^data[7:0]) ^ pbit;
      e.fe   = ~stopv;
      exp_q.push_back(e);
    end
    repeat (C) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      setLine(which, data[i]);
      repeat (C) @(negedge clk);
    end
    if (npar != 0) begin
      setLine(which, pbit);
      repeat (C) @(negedge clk);
    end
    for (int k = 0; k < nstop; k++) begin
      setLine(which, stopv);
      repeat (C) @(negedge clk);
    end
  endtask

  // Output-register model for instance A, advanced on each rising edge.
  initial forever begin
    @(posedge clk);
    exp_ovr = 1'b0;
    if (rst_a) begin
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_pe    = 1'b0;
      exp_fe    = 1'b0;
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (!exp_valid || ready_a) begin
        exp_valid = 1'b1;
        exp_data  = exp_q[0].data;
        exp_pe    = exp_q[0].pe;
        exp_fe    = exp_q[0].fe;
      end else begin
        exp_ovr = 1'b1;
      end
      void'(exp_q.pop_front());
    end else if (exp_valid && ready_a) begin
      exp_valid = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    checkOutput("valid_a", 32'(valid_a), 32'(exp_valid));
    checkOutput("overrun_a", 32'(ovr_a_o), 32'(exp_ovr));
    if (exp_valid) begin
      checkOutput("data_a", 32'(data_a), 32'(exp_data));
      checkOutput("perr_a", 32'(perr_a), 32'(exp_pe));
      checkOutput("ferr_a", 32'(ferr_a), 32'(exp_fe));
    end
  end

  initial forever begin
    @(negedge clk);
    if (valid_a && !prev_a) begin
      rise_a++; rise_cyc_a = cyc; cap_data_a = {1'b0, data_a}; cap_pe_a = perr_a; cap_fe_a = ferr_a;
    end
    if (valid_b && !prev_b) begin
      rise_b++; cap_data_b = {1'b0, data_b}; cap_pe_b = perr_b; cap_fe_b = ferr_b;
    end
    if (valid_c && !prev_c) begin
      rise_c++; rise_cyc_c = cyc; cap_data_c = data_c; cap_pe_c = perr_c; cap_fe_c = ferr_c;
    end
    prev_a = valid_a;
    prev_b = valid_b;
    prev_c = valid_c;
    if (ovr_a_o) ovr_a++;
    if (ovr_b_o) ovr_b++;
    if (ovr_c_o) ovr_c++;
  end

  initial begin
    int d, d2, g, r0, o0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(valid_a), 32'd0);
    checkOutput("rst_data", 32'(data_a), 32'd0);
    checkOutput("rst_flags", 32'({perr_a, ferr_a, ovr_a_o}), 32'd0);
    checkOutput("rst_valid_c", 32'(valid_c), 32'd0);
    rst_a = 1'b0;
    rst_c = 1'b0;
    repeat (10) @(negedge clk);

    r0 = rise_a;
    applyStimulus(0, 9'h0A5, 8, 1, 1'b0, 1, 1'b1, d);
    repeat (20) @(negedge clk);
    checkOutput("a5_count", 32'(rise_a - r0), 32'd1);
    checkOutput("a5_cycle", 32'(rise_cyc_a), 32'(d + SYNC + H + 10 * C + 1));
    checkOutput("a5_data", 32'(cap_data_a), 32'h0A5);
    checkOutput("a5_flags", 32'({cap_pe_a, cap_fe_a}), 32'd0);

    r0 = rise_a;
    applyStimulus(0, 9'h001, 8, 1, 1'b0, 1, 1'b1, d);
    repeat (20) @(negedge clk);
    checkOutput("p01_count", 32'(rise_a - r0), 32'd1);
    checkOutput("p01_data", 32'(cap_data_a), 32'h001);
    checkOutput("p01_perr", 32'(cap_pe_a), 32'd1);

    r0 = rise_a;
    @(negedge clk);
    rxd_a = 1'b0;
    g = cyc;
    repeat (4) @(negedge clk);
    rxd_a = 1'b1;
    while (cyc < g + SYNC + H + 1) @(negedge clk);
    checkOutput("glitch_idle", 32'(dut_a.state_q == RX_IDLE), 32'd1);
    repeat (200) @(negedge clk);
    checkOutput("glitch_none", 32'(rise_a - r0), 32'd0);

    r0 = rise_a;
    applyStimulus(0, 9'h03C, 8, 1, 1'b0, 1, 1'b0, d);
    repeat (40 * C) @(negedge clk);
    rxd_a = 1'b1;
    repeat (3 * C) @(negedge clk);
    checkOutput("ferr_count", 32'(rise_a - r0), 32'd1);
    checkOutput("ferr_data", 32'(cap_data_a), 32'h03C);
    checkOutput("ferr_flags", 32'({cap_pe_a, cap_fe_a}), 32'd1);

    ready_a = 1'b0;
    r0 = rise_a;
    o0 = ovr_a;
    applyStimulus(0, 9'h011, 8, 1, 1'b0, 1, 1'b1, d);
    applyStimulus(0, 9'h022, 8, 1, 1'b0, 1, 1'b1, d);
    repeat (20) @(negedge clk);
    checkOutput("ovr_count", 32'(ovr_a - o0), 32'd1);
    checkOutput("ovr_held_valid", 32'(valid_a), 32'd1);
    checkOutput("ovr_held_data", 32'(data_a), 32'h11);
    ready_a = 1'b1;
    @(negedge clk);
    checkOutput("ovr_drain", 32'(valid_a), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("ovr_rises", 32'(rise_a - r0), 32'd1);

    applyStimulus(1, 9'h001, 8, 1, 1'b0, 1, 1'b1, d);
    repeat (20) @(negedge clk);
    checkOutput("odd_count", 32'(rise_b), 32'd1);
    checkOutput("odd_data", 32'(cap_data_b), 32'h001);
    checkOutput("odd_flags", 32'({cap_pe_b, cap_fe_b}), 32'd0);
    checkOutput("odd_ovr", 32'(ovr_b), 32'd0);

    applyStimulus(2, 9'h1F3, 9, 0, 1'b0, 2, 1'b1, d);
    repeat (20) @(negedge clk);
    checkOutput("w9_count", 32'(rise_c), 32'd1);
    checkOutput("w9_cycle", 32'(rise_cyc_c), 32'(d + SYNC + H + 11 * C + 1));
    checkOutput("w9_data", 32'(cap_data_c), 32'h1F3);
    checkOutput("w9_flags", 32'({cap_pe_c, cap_fe_c}), 32'd0);

    fork
      applyStimulus(2, 9'h1FF, 9, 0, 1'b0, 2, 1'b1, d2);
      begin
        repeat (60) @(negedge clk);
        rst_c = 1'b1;
        #1;
        checkOutput("rstmid_valid", 32'(valid_c), 32'd0);
        checkOutput("rstmid_data", 32'(data_c), 32'd0);
        checkOutput("rstmid_flags", 32'({perr_c, ferr_c, ovr_c_o}), 32'd0);
        repeat (3) @(negedge clk);
        rst_c = 1'b0;
      end
    join
    repeat (30 * C) @(negedge clk);
    checkOutput("rstmid_nodeliv", 32'(rise_c), 32'd1);
    checkOutput("rstmid_noovr", 32'(ovr_c), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
